// File: rtl/triad_tx_arbiter_if.sv
// Triad-side request/release and UART-side frame bus of the triad transmit arbiter.
// The master modport is the arbiter's view; the slave modport is the triad/UART side.
interface triad_tx_arbiter_if #(
    parameter int N_TRIADS  = 4,
    parameter int ID_W      = 2,
    parameter int PAYLOAD_W = 102
);
    logic [N_TRIADS-1:0]           data_avl;
    logic [N_TRIADS*PAYLOAD_W-1:0] sensor_iterations;
    logic [N_TRIADS-1:0]           reset_parser;
    logic                          uart_data_avl;
    logic [PAYLOAD_W-1:0]          uart_payload;
    logic [ID_W-1:0]               uart_triad_id;
    logic                          uart_done;

    modport master (
        input  data_avl, sensor_iterations, uart_done,
        output reset_parser, uart_data_avl, uart_payload, uart_triad_id
    );

    modport slave (
        output data_avl, sensor_iterations, uart_done,
        input  reset_parser, uart_data_avl, uart_payload, uart_triad_id
    );
endinterface

// File: rtl/triad_tx_arbiter.sv
// Round-robin share of one UART between N_TRIADS triads; request to uart_data_avl in 1 cycle.
// Frame held until uart_done or timeout, then a one-cycle reset_parser pulse and a holdoff.
module triad_tx_arbiter #(
    parameter int N_TRIADS       = 4,
    parameter int ID_W           = 2,
    parameter int PAYLOAD_W      = 102,
    parameter int TIMEOUT_CYCLES = 262143,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic               clk_12MHz,
    input  logic               rst_n,
    triad_tx_arbiter_if.master bus,
    output logic               busy,
    output logic [7:0]         drop_count
);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HCNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RELEASE, S_HOLD} state_e;

    state_e               state_q,   state_d;
    logic [ID_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [N_TRIADS-1:0]  mask_q,    mask_d;
    logic [TMR_W-1:0]     timer_q,   timer_d;
    logic [HCNT_W-1:0]    hcnt_q,    hcnt_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [ID_W-1:0]      id_q,      id_d;
    logic [7:0]           drop_q,    drop_d;

    logic [N_TRIADS-1:0]  eligible;
    logic                 grant_vld;
    logic [ID_W-1:0]      grant_idx;
    logic                 timeout;

    assign eligible = bus.data_avl & ~mask_q;
    assign timeout  = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Scan from farthest to nearest so the last hit is the first triad after rr_ptr.
    always_comb begin
        int j;
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = N_TRIADS; k >= 1; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_TRIADS) begin
                j = j - N_TRIADS;
            end
            if (eligible[ID_W'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= ID_W'(N_TRIADS - 1);
            mask_q    <= '0;
            timer_q   <= '0;
            hcnt_q    <= '0;
            payload_q <= '0;
            id_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            mask_q    <= mask_d;
            timer_q   <= timer_d;
            hcnt_q    <= hcnt_d;
            payload_q <= payload_d;
            id_q      <= id_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        mask_d    = mask_q;
        timer_d   = timer_q;
        hcnt_d    = hcnt_q;
        payload_d = payload_q;
        id_d      = id_q;
        drop_d    = drop_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    payload_d = bus.sensor_iterations[int'(grant_idx)*PAYLOAD_W +: PAYLOAD_W];
                    id_d      = grant_idx;
                    timer_d   = '0;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                timer_d = timer_q + 1'b1;
                // A done pulse on the last timeout cycle still counts as a clean send.
                if (bus.uart_done) begin
                    state_d = S_RELEASE;
                end else if (timeout) begin
                    state_d = S_RELEASE;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            S_RELEASE: begin
                rr_ptr_d     = id_q;
                mask_d       = '0;
                mask_d[id_q] = 1'b1;
                hcnt_d       = '0;
                state_d      = S_HOLD;
            end
            S_HOLD: begin
                if (hcnt_q == HCNT_W'(HOLDOFF_CYCLES - 1)) begin
                    mask_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.uart_data_avl = (state_q == S_SEND);
        bus.uart_payload  = payload_q;
        bus.uart_triad_id = id_q;
        bus.reset_parser  = '0;
        if (state_q == S_RELEASE) begin
            bus.reset_parser[id_q] = 1'b1;
        end
        busy       = (state_q != S_IDLE);
        drop_count = drop_q;
    end
endmodule

// File: tb/tb_triad_tx_arbiter.sv
// Directed and randomized bench for triad_tx_arbiter with a transaction-level round-robin model.
module tb_triad_tx_arbiter;
    localparam int NT  = 4;
    localparam int PW  = 102;
    localparam int TMO = 16;
    localparam int HLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [7:0] drop_count;

    logic [PW-1:0] frame [NT];
    int n_pass = 0;
    int n_checks = 0;
    int last_grant = NT - 1;
    int exp_drops = 0;
    int g;

    triad_tx_arbiter_if #(.N_TRIADS(NT), .ID_W(2), .PAYLOAD_W(PW)) bus ();

    triad_tx_arbiter #(
        .N_TRIADS(NT), .ID_W(2), .PAYLOAD_W(PW),
        .TIMEOUT_CYCLES(TMO), .HOLDOFF_CYCLES(HLD)
    ) dut (
        .clk_12MHz  (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            bus.sensor_iterations[i*PW +: PW] = frame[i];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] rnd_frame();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    // First requesting triad strictly after the last granted one, wrapping.
    function automatic int pick(input logic [NT-1:0] req, input int last);
        for (int k = 1; k <= NT; k++) begin
            int j = (last + k) % NT;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.uart_done = 1'b0;
        @(negedge clk);
        check("rst_avl", 128'(bus.uart_data_avl), 128'(0));
        check("rst_rp", 128'(bus.reset_parser), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_drop", 128'(drop_count), 128'(0));
        check("rst_payload", 128'(bus.uart_payload), 128'(0));
        check("rst_id", 128'(bus.uart_triad_id), 128'(0));
        rst_n = 1'b1;
        last_grant = NT - 1;
        exp_drops = 0;
    endtask

    // Entered at a negedge in IDLE with data_avl already driven; leaves at the negedge IDLE is back.
    // d: SEND cycle on which uart_done is driven (> TMO means never); drop_after: release-relative
    // cycle on which the granted triad drops data_avl; scramble: change its frame/request mid-SEND.
    task automatic txn(input int d, input int drop_after, input bit scramble, output int gr);
        logic [PW-1:0] exp_pl;
        int rel_at;
        gr = pick(bus.data_avl, last_grant);
        exp_pl = frame[gr];
        rel_at = (d <= TMO) ? d : TMO;
        @(negedge clk);
        check("avl_rise", 128'(bus.uart_data_avl), 128'(1));
        check("grant_id", 128'(bus.uart_triad_id), 128'(gr));
        check("payload", 128'(bus.uart_payload), 128'(exp_pl));
        check("busy_send", 128'(busy), 128'(1));
        for (int m = 1; m <= rel_at; m++) begin
            if (m > 1) begin
                @(negedge clk);
                check("send_avl", 128'(bus.uart_data_avl), 128'(1));
                check("send_payload", 128'(bus.uart_payload), 128'(exp_pl));
                check("send_rp", 128'(bus.reset_parser), 128'(0));
            end
            if (m == 2 && scramble) begin
                frame[gr] = rnd_frame();
                bus.data_avl[gr] = 1'b0;
            end
            if (m == d) bus.uart_done = 1'b1;
        end
        @(negedge clk);
        bus.uart_done = 1'b0;
        if (d > TMO && exp_drops < 255) exp_drops++;
        check("release_rp", 128'(bus.reset_parser), 128'(1 << gr));
        check("release_avl", 128'(bus.uart_data_avl), 128'(0));
        check("drop_count", 128'(drop_count), 128'(exp_drops));
        last_grant = gr;
        if (drop_after == 0) bus.data_avl[gr] = 1'b0;
        for (int k = 1; k <= HLD; k++) begin
            @(negedge clk);
            check("hold_rp", 128'(bus.reset_parser), 128'(0));
            check("hold_busy", 128'(busy), 128'(1));
            bus.uart_done = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == drop_after) bus.data_avl[gr] = 1'b0;
        end
        @(negedge clk);
        check("idle_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        bus.data_avl = '0;
        bus.uart_done = 1'b0;
        for (int i = 0; i < NT; i++) frame[i] = '0;

        // T1: single request from triad 1
        do_reset();
        frame[1] = 102'hABC;
        bus.data_avl = 4'b0010;
        txn(10, 0, 1'b0, g);
        check("t1_grant", 128'(g), 128'(1));

        // T6: done coincides with the timeout cycle
        bus.data_avl = 4'b0100;
        frame[2] = rnd_frame();
        txn(TMO, 0, 1'b0, g);
        check("t6_no_drop", 128'(drop_count), 128'(0));

        // T2: all four requesting, each drops 2 cycles after its release
        do_reset();
        for (int i = 0; i < NT; i++) frame[i] = rnd_frame();
        bus.data_avl = 4'b1111;
        for (int i = 0; i < NT; i++) begin
            txn($urandom_range(1, 12), 2, 1'b0, g);
            check("t2_order", 128'(g), 128'(i));
        end
        bus.data_avl = 4'b1111;
        txn(3, 2, 1'b0, g);
        check("t2_wrap", 128'(g), 128'(0));
        bus.data_avl = 4'b0000;

        // T4: stale triad-2 request through the holdoff is not re-granted
        bus.data_avl = 4'b0100;
        txn(4, 3, 1'b0, g);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_no_regrant", 128'(busy), 128'(0));
        end
        bus.data_avl = 4'b0100;
        txn(5, 0, 1'b0, g);
        check("t4_new_grant", 128'(g), 128'(2));

        // T3: repeated timeouts saturate drop_count
        for (int i = 0; i < 256; i++) begin
            bus.data_avl = 4'b0100;
            txn(TMO + 1, 0, 1'b0, g);
            if (i == 0) check("t3_first_drop", 128'(drop_count), 128'(1));
        end
        check("t3_saturate", 128'(drop_count), 128'(255));

        // T5: reset in the middle of SEND
        bus.data_avl = 4'b0001;
        txn(3, 0, 1'b0, g);
        bus.data_avl = 4'b0010;
        @(negedge clk);
        check("t5_send", 128'(bus.uart_triad_id), 128'(1));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.data_avl = 4'b0011;
        @(negedge clk);
        check("t5_avl", 128'(bus.uart_data_avl), 128'(0));
        check("t5_rp", 128'(bus.reset_parser), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_drop", 128'(drop_count), 128'(0));
        check("t5_payload", 128'(bus.uart_payload), 128'(0));
        check("t5_id", 128'(bus.uart_triad_id), 128'(0));
        rst_n = 1'b1;
        last_grant = NT - 1;
        exp_drops = 0;
        txn(5, 0, 1'b0, g);
        check("t5_next_grant", 128'(g), 128'(0));

        // Randomized traffic against the round-robin model
        for (int t = 0; t < 60; t++) begin
            logic [NT-1:0] add;
            int r;
            add = NT'($urandom_range(0, 15));
            for (int i = 0; i < NT; i++) begin
                if (add[i] && !bus.data_avl[i]) frame[i] = rnd_frame();
            end
            bus.data_avl = bus.data_avl | add;
            if (bus.data_avl == '0) begin
                r = $urandom_range(0, NT - 1);
                frame[r] = rnd_frame();
                bus.data_avl[r] = 1'b1;
            end
            txn($urandom_range(1, 20), $urandom_range(0, 4), 1'($urandom_range(0, 1)), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
